// File: rtl/trig_enc_pkg.sv
// Shared definitions for the registered CFEB trigger-code encoder:
// code constants, channel state type and the input-to-code mapping.
package trig_enc_pkg;

    localparam logic [2:0] CODE_IDLE       = 3'd0;
    localparam logic [2:0] CODE_LCT        = 3'd1;
    localparam logic [2:0] CODE_LCT_L1A    = 3'd2;
    localparam logic [2:0] CODE_LCT_L1A_M  = 3'd3;
    localparam logic [2:0] CODE_L1A        = 3'd4;
    localparam logic [2:0] CODE_L1A_M      = 3'd5;
    localparam logic [2:0] CODE_RSYNC      = 3'd7;

    // S_ prefix keeps the literals clear of the HOLD parameter name.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } chan_state_e;

    // Map {RESYNC_RST, L1A_MATCH[i], L1ACFEB, PRE_LCT_OUT[i]} to a trigger code.
    function automatic logic [2:0] enc_code(input logic rsync,
                                            input logic l1a_match,
                                            input logic l1acfeb,
                                            input logic pre_lct);
        logic [2:0] c;
        c = CODE_IDLE;
        if (rsync) begin
            c = CODE_RSYNC;
        end else begin
            case ({l1a_match, l1acfeb, pre_lct})
                3'b001:  c = CODE_LCT;
                3'b011:  c = CODE_LCT_L1A;
                3'b111:  c = CODE_LCT_L1A_M;
                3'b010:  c = CODE_L1A;
                3'b110:  c = CODE_L1A_M;
                default: c = CODE_IDLE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/trig_enc_chan.sv
// One encoder channel: hold FSM, hold counter, small code FIFO and sticky
// overflow flag. code_nxt_o is the code to be driven next cycle.
module trig_enc_chan
    import trig_enc_pkg::*;
#(
    parameter int unsigned HOLD     = 2,
    parameter int unsigned QDEPTH_W = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic [2:0] code_i,
    input  logic       ovf_clr_i,
    output logic [2:0] code_nxt_o,
    output logic       ovf_o
);

    localparam int unsigned        DEPTH    = 1 << QDEPTH_W;
    localparam logic [3:0]         HOLD_LD  = 4'(HOLD - 1);
    localparam logic [QDEPTH_W:0]  FULL_CNT = (QDEPTH_W + 1)'(DEPTH);

    chan_state_e          state_q, state_d;
    logic [3:0]           hold_q, hold_d;
    logic [2:0]           code_q, code_d;
    logic [2:0]           mem_q [DEPTH];
    logic [QDEPTH_W-1:0]  wr_q, rd_q;
    logic [QDEPTH_W:0]    cnt_q, cnt_d;
    logic                 ovf_q;
    logic                 push, pop, flush;
    logic                 full, empty, push_ok, ovf_set;
    logic                 in_valid;

    assign in_valid = (code_i != CODE_IDLE);
    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    // A pop in the same cycle frees a slot, so push is legal even when full.
    assign push_ok  = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;

    // Next-state logic: hold sequencing, queue push/pop decisions.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (clr_i) begin
            state_d = S_IDLE;
            hold_d  = '0;
            code_d  = CODE_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_HOLD;
                        code_d  = code_i;
                        hold_d  = HOLD_LD;
                    end
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        if (!empty) begin
                            // Head goes out; a code arriving now joins the tail.
                            pop    = 1'b1;
                            code_d = mem_q[rd_q];
                            hold_d = HOLD_LD;
                            push   = in_valid;
                        end else if (in_valid) begin
                            code_d = code_i;
                            hold_d = HOLD_LD;
                        end else begin
                            state_d = S_IDLE;
                            code_d  = CODE_IDLE;
                        end
                    end else begin
                        hold_d = hold_q - 4'd1;
                        push   = in_valid;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    code_d  = CODE_IDLE;
                end
            endcase
        end
    end

    // Queue occupancy update.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State, counters, pointers and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            code_q  <= CODE_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push_ok) wr_q <= wr_q + 1'b1;
                if (pop)     rd_q <= rd_q + 1'b1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= code_i;
        end
    end

    assign code_nxt_o = code_d;
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/trig_enc_fifo.sv
// Registered NCHAN-channel CFEB trigger encoder: mode decode, shared resync
// stretcher with broadcast of code 7, passthrough mux and output registers.
module trig_enc_fifo
    import trig_enc_pkg::*;
#(
    parameter int unsigned NCHAN      = 5,
    parameter int unsigned HOLD       = 2,
    parameter int unsigned QDEPTH_W   = 2,
    parameter int unsigned RSYNC_HOLD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENCODE,
    input  logic             DCFEB_IN_USE,
    input  logic             RESYNC_RST,
    input  logic             L1ACFEB,
    input  logic [NCHAN-1:0] PRE_LCT_OUT,
    input  logic [NCHAN-1:0] L1A_MATCH,
    input  logic             OVF_CLR,
    output logic [NCHAN-1:0] ENC_BIT0,
    output logic [NCHAN-1:0] ENC_BIT1,
    output logic [NCHAN-1:0] ENC_BIT2,
    output logic [NCHAN-1:0] OVERFLOW
);

    localparam logic [3:0] RSYNC_LD = 4'(RSYNC_HOLD - 1);

    logic             enc_mode;
    logic             rsync_act_q, rsync_act_d;
    logic [3:0]       rsync_cnt_q, rsync_cnt_d;
    logic             drive7;
    logic             chan_clr;
    logic [2:0]       in_code  [NCHAN];
    logic [2:0]       chan_nxt [NCHAN];
    logic [NCHAN-1:0] enc0_q, enc0_d;
    logic [NCHAN-1:0] enc1_q, enc1_d;
    logic [NCHAN-1:0] enc2_q, enc2_d;

    assign enc_mode = ENCODE & ~DCFEB_IN_USE;
    // Channels stay idle and empty outside encoded mode and throughout resync.
    assign chan_clr = ~enc_mode | RESYNC_RST | rsync_act_q;

    // Resync stretcher: reload on every RESYNC_RST, broadcast 7 until expiry.
    always_comb begin
        rsync_act_d = rsync_act_q;
        rsync_cnt_d = rsync_cnt_q;
        drive7      = 1'b0;
        if (!enc_mode) begin
            rsync_act_d = 1'b0;
            rsync_cnt_d = '0;
        end else if (RESYNC_RST) begin
            rsync_act_d = 1'b1;
            rsync_cnt_d = RSYNC_LD;
            drive7      = 1'b1;
        end else if (rsync_act_q) begin
            if (rsync_cnt_q == '0) begin
                rsync_act_d = 1'b0;
            end else begin
                rsync_cnt_d = rsync_cnt_q - 4'd1;
                drive7      = 1'b1;
            end
        end
    end

    // Resync state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsync_act_q <= 1'b0;
            rsync_cnt_q <= '0;
        end else begin
            rsync_act_q <= rsync_act_d;
            rsync_cnt_q <= rsync_cnt_d;
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        assign in_code[g] = enc_code(1'b0, L1A_MATCH[g], L1ACFEB, PRE_LCT_OUT[g]);

        trig_enc_chan #(
            .HOLD     (HOLD),
            .QDEPTH_W (QDEPTH_W)
        ) u_chan (
            .clk_i      (CLK),
            .rst_i      (RST),
            .clr_i      (chan_clr),
            .code_i     (in_code[g]),
            .ovf_clr_i  (OVF_CLR),
            .code_nxt_o (chan_nxt[g]),
            .ovf_o      (OVERFLOW[g])
        );
    end

    // Output select: passthrough, resync broadcast, or per-channel code.
    always_comb begin
        enc0_d = '0;
        enc1_d = '0;
        enc2_d = '0;
        if (!enc_mode) begin
            enc0_d = DCFEB_IN_USE ? L1A_MATCH : PRE_LCT_OUT;
            enc1_d = {NCHAN{L1ACFEB}};
            enc2_d = {NCHAN{RESYNC_RST}};
        end else if (drive7) begin
            enc0_d = '1;
            enc1_d = '1;
            enc2_d = '1;
        end else begin
            for (int unsigned i = 0; i < NCHAN; i++) begin
                enc0_d[i] = chan_nxt[i][0];
                enc1_d[i] = chan_nxt[i][1];
                enc2_d[i] = chan_nxt[i][2];
            end
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            enc0_q <= '0;
            enc1_q <= '0;
            enc2_q <= '0;
        end else begin
            enc0_q <= enc0_d;
            enc1_q <= enc1_d;
            enc2_q <= enc2_d;
        end
    end

    assign ENC_BIT0 = enc0_q;
    assign ENC_BIT1 = enc1_q;
    assign ENC_BIT2 = enc2_q;

endmodule

// File: tb/tb_trig_enc_fifo.sv
// Directed bench for trig_enc_fifo: dut_a uses default parameters,
// dut_b uses HOLD=8 so several codes can queue behind a single hold.
module tb_trig_enc_fifo;

    logic       CLK = 1'b0;
    logic       RST, ENCODE, DCFEB_IN_USE, RESYNC_RST, L1ACFEB, OVF_CLR;
    logic [4:0] PRE_LCT_OUT, L1A_MATCH;
    logic [4:0] a_b0, a_b1, a_b2, a_ovf;
    logic [4:0] b_b0, b_b1, b_b2, b_ovf;

    int n_chk = 0;
    int n_bad = 0;

    trig_enc_fifo dut_a (
        .CLK(CLK), .RST(RST), .ENCODE(ENCODE), .DCFEB_IN_USE(DCFEB_IN_USE),
        .RESYNC_RST(RESYNC_RST), .L1ACFEB(L1ACFEB), .PRE_LCT_OUT(PRE_LCT_OUT),
        .L1A_MATCH(L1A_MATCH), .OVF_CLR(OVF_CLR),
        .ENC_BIT0(a_b0), .ENC_BIT1(a_b1), .ENC_BIT2(a_b2), .OVERFLOW(a_ovf)
    );

    trig_enc_fifo #(.HOLD(8)) dut_b (
        .CLK(CLK), .RST(RST), .ENCODE(ENCODE), .DCFEB_IN_USE(DCFEB_IN_USE),
        .RESYNC_RST(RESYNC_RST), .L1ACFEB(L1ACFEB), .PRE_LCT_OUT(PRE_LCT_OUT),
        .L1A_MATCH(L1A_MATCH), .OVF_CLR(OVF_CLR),
        .ENC_BIT0(b_b0), .ENC_BIT1(b_b1), .ENC_BIT2(b_b2), .OVERFLOW(b_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        ENCODE       = 1'b1;
        DCFEB_IN_USE = 1'b0;
        RESYNC_RST   = 1'b0;
        L1ACFEB      = 1'b0;
        OVF_CLR      = 1'b0;
        PRE_LCT_OUT  = '0;
        L1A_MATCH    = '0;
    endtask

    task automatic do_reset();
        clear_in();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    function automatic logic [2:0] cha(input int i);
        return {a_b2[i], a_b1[i], a_b0[i]};
    endfunction

    function automatic logic [2:0] chb(input int i);
        return {b_b2[i], b_b1[i], b_b0[i]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [2:0] seq2 [7];
        logic [2:0] seq3 [5];
        logic [2:0] e;
        seq2 = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd5, 3'd0};
        seq3 = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd5};

        // Reset state
        RST = 1'b1;
        clear_in();
        tick();
        tick();
        check("rst_a", {17'd0, a_b2, a_b1, a_b0}, 32'd0);
        check("rst_ovf", {22'd0, a_ovf, b_ovf}, 32'd0);
        RST = 1'b0;
        tick();
        check("idle_a", {17'd0, a_b2, a_b1, a_b0}, 32'd0);

        // Single pre-LCT on channel 2
        PRE_LCT_OUT = 5'b00100;
        tick();
        PRE_LCT_OUT = '0;
        check("lct_c1", {17'd0, a_b2, a_b1, a_b0}, 32'h0004);
        tick();
        check("lct_c2", {17'd0, a_b2, a_b1, a_b0}, 32'h0004);
        tick();
        check("lct_c3", {17'd0, a_b2, a_b1, a_b0}, 32'd0);
        check("lct_ovf", {27'd0, a_ovf}, 32'd0);

        // Back-to-back codes on channel 1: 1,1,2,2,5,5,0
        do_reset();
        PRE_LCT_OUT = 5'b00010;
        tick();
        check("seq_0", {29'd0, cha(1)}, {29'd0, seq2[0]});
        L1ACFEB = 1'b1;
        tick();
        check("seq_1", {29'd0, cha(1)}, {29'd0, seq2[1]});
        PRE_LCT_OUT = '0;
        L1A_MATCH   = 5'b00010;
        tick();
        check("seq_2", {29'd0, cha(1)}, {29'd0, seq2[2]});
        clear_in();
        for (int k = 3; k < 7; k++) begin
            tick();
            check($sformatf("seq_%0d", k), {29'd0, cha(1)}, {29'd0, seq2[k]});
        end

        // Queue overflow on dut_b channel 3 (HOLD=8, depth 4)
        do_reset();
        PRE_LCT_OUT = 5'b01000;                                     tick(); // A=1
        L1ACFEB = 1'b1;                                             tick(); // B=2
        L1ACFEB = 1'b0;                                             tick(); // C=1
        L1ACFEB = 1'b1; L1A_MATCH = 5'b01000;                       tick(); // D=3
        PRE_LCT_OUT = '0;                                           tick(); // E=5
        PRE_LCT_OUT = 5'b01000; L1A_MATCH = '0;                     tick(); // F=2 dropped
        clear_in();
        check("ovf_set", {27'd0, b_ovf}, 32'h08);
        check("ovf_out6", {29'd0, chb(3)}, 32'd1);
        for (int t = 7; t <= 41; t++) begin
            tick();
            e = (t <= 40) ? seq3[(t - 1) / 8] : 3'd0;
            check($sformatf("q_t%0d", t), {29'd0, chb(3)}, {29'd0, e});
        end
        check("ovf_sticky", {27'd0, b_ovf}, 32'h08);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("ovf_clr", {27'd0, b_ovf}, 32'd0);

        // Resync with a non-empty queue on channel 0
        do_reset();
        PRE_LCT_OUT = 5'b00001;
        tick();
        tick();
        tick();
        PRE_LCT_OUT = '0;
        RESYNC_RST  = 1'b1;
        tick();
        RESYNC_RST  = 1'b0;
        check("rs_1", {17'd0, a_b2, a_b1, a_b0}, 32'h7fff);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("rs_%0d", k), {17'd0, a_b2, a_b1, a_b0}, 32'h7fff);
        end
        for (int k = 5; k <= 7; k++) begin
            tick();
            check($sformatf("rs_%0d", k), {17'd0, a_b2, a_b1, a_b0}, 32'd0);
        end
        check("rs_ovf", {27'd0, a_ovf}, 32'd0);

        // Resync reasserted during stretch extends it
        do_reset();
        RESYNC_RST = 1'b1; tick();
        RESYNC_RST = 1'b0; tick();
        RESYNC_RST = 1'b1; tick();
        RESYNC_RST = 1'b0;
        check("rr_3", {17'd0, a_b2, a_b1, a_b0}, 32'h7fff);
        for (int k = 4; k <= 6; k++) begin
            tick();
            check($sformatf("rr_%0d", k), {17'd0, a_b2, a_b1, a_b0}, 32'h7fff);
        end
        tick();
        check("rr_7", {17'd0, a_b2, a_b1, a_b0}, 32'd0);

        // DCFEB passthrough mid-hold, then back to encoded mode
        do_reset();
        PRE_LCT_OUT = 5'b10000;
        tick();
        check("dc_h1", {29'd0, cha(4)}, 32'd1);
        tick();
        check("dc_h2", {29'd0, cha(4)}, 32'd1);
        PRE_LCT_OUT  = '0;
        DCFEB_IN_USE = 1'b1;
        L1A_MATCH    = 5'b10101;
        L1ACFEB      = 1'b1;
        tick();
        check("dc_pass", {17'd0, a_b2, a_b1, a_b0}, {17'd0, 5'b00000, 5'b11111, 5'b10101});
        clear_in();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("dc_flush%0d", k), {17'd0, a_b2, a_b1, a_b0}, 32'd0);
        end

        // Plain passthrough (ENCODE=0): PRE_LCT_OUT on bit 0, resync on bit 2
        ENCODE      = 1'b0;
        PRE_LCT_OUT = 5'b01010;
        RESYNC_RST  = 1'b1;
        tick();
        check("pt_enc0", {17'd0, a_b2, a_b1, a_b0}, {17'd0, 5'b11111, 5'b00000, 5'b01010});
        clear_in();
        tick();
        check("pt_back", {17'd0, a_b2, a_b1, a_b0}, 32'd0);

        // Reset mid-hold with a full queue and overflow set on dut_b
        do_reset();
        PRE_LCT_OUT = 5'b00001;
        for (int k = 0; k < 6; k++) tick();
        check("rh_ovf_b", {27'd0, b_ovf}, 32'h01);
        check("rh_ovf_a", {27'd0, a_ovf}, 32'h00);
        PRE_LCT_OUT = '0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rh_out", {2'd0, b_b2, b_b1, b_b0, a_b2, a_b1, a_b0}, 32'd0);
        check("rh_ovf", {22'd0, a_ovf, b_ovf}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rh_idle%0d", k), {2'd0, b_b2, b_b1, b_b0, a_b2, a_b1, a_b0}, 32'd0);
        end
        PRE_LCT_OUT = 5'b00100;
        tick();
        PRE_LCT_OUT = '0;
        check("rh_new_a", {17'd0, a_b2, a_b1, a_b0}, 32'h0004);
        check("rh_new_b", {29'd0, chb(2)}, 32'd1);
        tick();
        check("rh_new_a2", {29'd0, cha(2)}, 32'd1);
        tick();
        check("rh_new_a3", {29'd0, cha(2)}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
